lif_scheduler: RTL
==================

Name: lif_scheduler

Overview:
Time-multiplexed sequencer that shares one leaky integrate-and-fire update datapath among N_NEURONS neurons. Membrane states and refractory counters live in internal register arrays. On each timestep tick the FSM sweeps the neurons one per cycle and publishes a spike vector. It sits between the tile I/O wrapper (tick, currents, readback select) and the spike and state outputs.

Parameters:
N_NEURONS, 4, number of neurons sharing the datapath (2..16)
STATE_W, 8, membrane state and input current width (bits)
THRESHOLD, 200, firing threshold (unsigned, < 2**STATE_W)
DECAY_SHIFT, 1, leak = state >> DECAY_SHIFT
REFRAC, 2, refractory length in timesteps (0 = none)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  timestep request; sampled on the rising edge of clk
cur_in  in  N_NEURONS*STATE_W  per-neuron input current; neuron i = bits [i*STATE_W +: STATE_W]
rd_idx  in  clog2(N_NEURONS)  state readback select
clr_ovr  in  1  clears the overrun flag
busy  out  1  high while a sweep is in progress
spikes  out  N_NEURONS  spike vector from the last completed timestep
spikes_valid  out  1  one-cycle pulse when spikes is updated
rd_state  out  STATE_W  membrane state of neuron rd_idx, registered
overrun  out  1  sticky flag: a tick arrived while not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset value of all outputs is 0. All membrane states, refractory counters, the index and the shadow spike vector are also 0. FSM state = IDLE.
- FSM states are IDLE, UPDATE and DONE.
- IDLE: if tick=1, latch all of cur_in into the current buffer, set idx=0, clear the shadow spike vector, then go to UPDATE. busy=1 from the next cycle.
- UPDATE: process neuron idx in one cycle using the latched current c and the stored state s.
  - If refrac[idx] > 0: s' = 0, refrac[idx] decrements, no spike.
  - Otherwise compute sum = (s - (s >> DECAY_SHIFT)) + c at STATE_W+1 bits, with no wrap.
  - If sum >= THRESHOLD: set shadow[idx]=1, s' = 0, refrac[idx] = REFRAC.
  - Else s' = sum. This always fits in STATE_W because THRESHOLD < 2**STATE_W.
- idx advances by 1 each cycle. After idx = N_NEURONS-1 is written, go to DONE.
- DONE, lasting one cycle:
  - spikes <= shadow and spikes_valid = 1.
  - busy = 0 in this cycle.
  - Next state is IDLE.
- Latency: with tick sampled at edge T, the neurons are written at edges T+1..T+N and spikes_valid is high in the cycle after edge T+N+1. For N=4: 5 edges from tick to the spikes_valid edge.
- spikes holds its value until the next DONE. spikes_valid is high for exactly one cycle per sweep.
- Ticks while not IDLE, including during DONE:
  - The tick is ignored and overrun is set to 1.
  - The sweep in progress and the latched currents are unaffected.
- overrun clears only on clr_ovr=1 or rst. If a tick and clr_ovr arrive in the same cycle, the set wins.
- Changes to cur_in during a sweep have no effect, because currents are latched only at the tick edge.
- rd_state <= state[rd_idx] every cycle, 1-cycle latency. It reflects a write made in the same cycle on the following cycle.
- Reset mid-sweep aborts the sweep: all arrays are cleared, no spikes_valid is produced, and the block returns to IDLE.
- Only one datapath instance is allowed (one adder/comparator). States are addressed by idx.

Test Plan (N=4, THRESHOLD=200, DECAY_SHIFT=1, REFRAC=2):
1. Reset: assert rst for 2 cycles -> all outputs 0; rd_state=0 for every rd_idx; busy stays 0 with tick=0.
2. Integrate and fire: cur=[150,0,0,0], tick 1 -> spikes=0000 and neuron 0 state=150. Tick 2 -> 150-75+150=225 ≥ 200, so spikes=0001 and state=0. spikes_valid pulses exactly once per tick, 5 edges after it.
3. Refractory: continue cur0=150 -> ticks 3 and 4 give spikes=0000 and state 0. Tick 5 gives state=150. Tick 6 gives spikes=0001.
4. Leak and independence: cur=[0,40,255,0], prior states 0. Tick 1 -> states [0,40,0,0] and spikes=0100. Tick 2 -> neuron 1 = 40-20+40 = 60.
5. Overrun: tick again 2 cycles after a tick -> overrun=1, sweep completes with the unchanged result, a single spikes_valid. clr_ovr -> overrun=0. Simultaneous tick-while-busy and clr_ovr -> overrun=1.
6. Reset mid-sweep: assert rst when idx=2 -> busy=0, no spikes_valid, states 0. A following tick with cur0=150 gives state 150 and no spike.

Source files
------------

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - time-multiplexed leaky integrate-and-fire neuron sequencer
module lif_scheduler #(
   parameter int N_NEURONS   = 4,
   parameter int STATE_W     = 8,
   parameter int THRESHOLD   = 200,
   parameter int DECAY_SHIFT = 1,
   parameter int REFRAC      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tick,
   input  logic [N_NEURONS*STATE_W-1:0] cur_in,
   input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
   input  logic                         clr_ovr,
   output logic                         busy,
   output logic [N_NEURONS-1:0]         spikes,
   output logic                         spikes_valid,
   output logic [STATE_W-1:0]           rd_state,
   output logic                         overrun
);
   localparam int IW = $clog2(N_NEURONS);
   localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
   localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} fsm_t;

   fsm_t                         fsm_q, fsm_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [N_NEURONS*STATE_W-1:0] cur_q, cur_d;
   logic [N_NEURONS-1:0]         shadow_q, shadow_d;
   logic [STATE_W-1:0]           mem_q [N_NEURONS];
   logic [STATE_W-1:0]           mem_d [N_NEURONS];
   logic [RW-1:0]                refrac_q [N_NEURONS];
   logic [RW-1:0]                refrac_d [N_NEURONS];
   logic                         busy_q, busy_d;
   logic [N_NEURONS-1:0]         spikes_q, spikes_d;
   logic                         spikes_valid_q, spikes_valid_d;
   logic [STATE_W-1:0]           rd_state_q, rd_state_d;
   logic                         overrun_q, overrun_d;

   // The single shared datapath: operands are selected by idx from the arrays.
   logic [STATE_W-1:0] s_cur;
   logic [STATE_W-1:0] c_cur;
   logic [RW-1:0]      r_cur;
   logic [STATE_W-1:0] leaked;
   logic [STATE_W:0]   sum;
   logic               fire;

   always_comb begin
      s_cur  = mem_q[idx_q];
      c_cur  = cur_q[int'(idx_q)*STATE_W +: STATE_W];
      r_cur  = refrac_q[idx_q];
      leaked = s_cur - (s_cur >> DECAY_SHIFT);
      sum    = {1'b0, leaked} + {1'b0, c_cur};
      fire   = (sum >= (STATE_W+1)'(THRESHOLD));
   end

   always_comb begin
      fsm_d          = fsm_q;
      idx_d          = idx_q;
      cur_d          = cur_q;
      shadow_d       = shadow_q;
      mem_d          = mem_q;
      refrac_d       = refrac_q;
      busy_d         = busy_q;
      spikes_d       = spikes_q;
      spikes_valid_d = 1'b0;
      rd_state_d     = '0;
      overrun_d      = overrun_q;

      // A tick outside IDLE is dropped but recorded; setting beats clearing.
      if (clr_ovr)
         overrun_d = 1'b0;
      if (tick && (fsm_q != IDLE))
         overrun_d = 1'b1;

      case (fsm_q)
         IDLE: begin
            if (tick) begin
               cur_d    = cur_in;
               idx_d    = '0;
               shadow_d = '0;
               busy_d   = 1'b1;
               fsm_d    = UPDATE;
            end
         end
         UPDATE: begin
            if (r_cur != '0) begin
               mem_d[idx_q]    = '0;
               refrac_d[idx_q] = r_cur - RW'(1);
            end else if (fire) begin
               shadow_d[idx_q] = 1'b1;
               mem_d[idx_q]    = '0;
               refrac_d[idx_q] = RW'(REFRAC);
            end else begin
               mem_d[idx_q] = sum[STATE_W-1:0];
            end
            if (idx_q == LAST) begin
               busy_d = 1'b0;
               fsm_d  = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            spikes_d       = shadow_q;
            spikes_valid_d = 1'b1;
            fsm_d          = IDLE;
         end
         default: fsm_d = IDLE;
      endcase

      if (int'(rd_idx) < N_NEURONS)
         rd_state_d = mem_q[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q          <= IDLE;
         idx_q          <= '0;
         cur_q          <= '0;
         shadow_q       <= '0;
         mem_q          <= '{default: '0};
         refrac_q       <= '{default: '0};
         busy_q         <= 1'b0;
         spikes_q       <= '0;
         spikes_valid_q <= 1'b0;
         rd_state_q     <= '0;
         overrun_q      <= 1'b0;
      end else begin
         fsm_q          <= fsm_d;
         idx_q          <= idx_d;
         cur_q          <= cur_d;
         shadow_q       <= shadow_d;
         mem_q          <= mem_d;
         refrac_q       <= refrac_d;
         busy_q         <= busy_d;
         spikes_q       <= spikes_d;
         spikes_valid_q <= spikes_valid_d;
         rd_state_q     <= rd_state_d;
         overrun_q      <= overrun_d;
      end
   end

   assign busy         = busy_q;
   assign spikes       = spikes_q;
   assign spikes_valid = spikes_valid_q;
   assign rd_state     = rd_state_q;
   assign overrun      = overrun_q;
endmodule
